tap_decoder: RTL

Counts debounced button presses into tap events: single, double, triple and so on. It sits directly downstream of the button debouncer and takes that block's one-cycle press pulses. Presses that fall inside a rolling inactivity window are grouped into one event carrying the tap count. Each event goes to the control logic over a valid/ready handshake.

---
 rtl/tap_pkg.sv | 17 +
 rtl/tap_event_fifo.sv | 60 ++++++
 rtl/tap_decoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/tap_pkg.sv
// Shared types and constants for the tap decoder.
package tap_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } tap_state_t;

  localparam int DEF_WINDOW_CYCLES = 50;
  localparam int DEF_MAX_TAPS      = 7;

  // Width needed to hold a tap count in 0..max_taps.
  function automatic int count_w(input int max_taps);
    return $clog2(max_taps + 1);
  endfunction

endpackage

// File: rtl/tap_event_fifo.sv
// Event storage for the tap decoder: in-order queue with push/pop, full/empty
// and a drop flag for a push that cannot be stored. DEPTH=1 acts as a single
// holding register. A pop on a full queue frees the slot for the same-cycle push.
module tap_event_fifo
  import tap_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/tap_decoder.sv
// Groups debounced press pulses into tap events (single, double, ...).
// A group closes after WINDOW_CYCLES cycles without a press; the event is
// queued and offered on a valid/ready handshake.
// Build option: define TAP_FIFO_EN for a FIFO_DEPTH-entry event queue;
// otherwise a single holding register is used.
module tap_decoder
  import tap_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int MAX_TAPS      = DEF_MAX_TAPS,
  parameter int FIFO_DEPTH    = 4,
  localparam int COUNT_W      = count_w(MAX_TAPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               press_in,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [COUNT_W-1:0] evt_taps,
  output logic               busy,
  output logic               overflow
);

  localparam int TW = $clog2(WINDOW_CYCLES);

`ifdef TAP_FIFO_EN
  localparam int STORE_DEPTH = FIFO_DEPTH;
`else
  localparam int STORE_DEPTH = 1;
`endif

  // Parameter sanity checks at elaboration.
  if (WINDOW_CYCLES < 2) begin : g_bad_window
    $error("tap_decoder: WINDOW_CYCLES must be >= 2");
  end
  if (MAX_TAPS < 1) begin : g_bad_max
    $error("tap_decoder: MAX_TAPS must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tap_decoder: FIFO_DEPTH must be a power of two >= 2");
  end

  tap_state_t        state;
  logic [COUNT_W-1:0] taps;
  logic [TW-1:0]      timer;
  logic               expire;
  logic               store_full;
  logic               store_empty;

  assign expire = (state == COLLECT) && !press_in && (timer == TW'(WINDOW_CYCLES - 1));
  assign busy   = (state == COLLECT);

  // Group FSM: press opens or extends a group; a full quiet window closes it.
  // A press on the expiry cycle keeps the group open.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      taps  <= '0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press_in) begin
            taps  <= COUNT_W'(1);
            timer <= '0;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (press_in) begin
            if (taps != COUNT_W'(MAX_TAPS)) taps <= taps + 1'b1;
            timer <= '0;
          end else if (expire) begin
            state <= IDLE;
            taps  <= '0;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tap_event_fifo #(
    .DEPTH (STORE_DEPTH),
    .WIDTH (COUNT_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .push    (expire),
    .pop     (evt_ready),
    .wr_data (taps),
    .rd_data (evt_taps),
    .full    (store_full),
    .empty   (store_empty),
    .drop    (overflow)
  );

  assign evt_valid = !store_empty;

  logic unused_full;
  assign unused_full = store_full;

endmodule
